// File: rtl/fifo_ms_rr_sched.sv
// Round-robin drain scheduler for a multi-stream FIFO: pops one stream per cycle
// with a bounded burst length and presents the word on a registered valid/ready port.
module fifo_ms_rr_sched #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FLUX       = 2,
    parameter int unsigned BURST      = 2
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [FLUX-1:0]                           empty,
    input  logic [DATA_WIDTH+$clog2(FLUX)-1:0]        dout,
    output logic [FLUX-1:0]                           read,
    input  logic [FLUX-1:0]                           en_mask,
    input  logic                                      pause,
    output logic                                      m_valid,
    input  logic                                      m_ready,
    output logic [DATA_WIDTH-1:0]                     m_data,
    output logic [$clog2(FLUX)-1:0]                   m_tag,
    output logic                                      tag_err
);

    localparam int unsigned TAG_WIDTH = $clog2(FLUX);
    localparam int unsigned CNT_WIDTH = $clog2(BURST + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SERVE = 2'd1;
    localparam logic [1:0] STALL = 2'd2;

    logic [1:0]           state;
    logic [1:0]           state_next;
    logic [FLUX-1:0]      eligible;
    logic [TAG_WIDTH-1:0] cur;
    logic [TAG_WIDTH-1:0] grant;
    logic [CNT_WIDTH-1:0] burst_cnt;
    logic                 keep;
    logic                 can_pop;
    logic [TAG_WIDTH-1:0] dout_tag;

    assign eligible = ~empty & en_mask;
    assign keep     = eligible[cur] && (burst_cnt < CNT_WIDTH'(BURST));
    assign can_pop  = rst && (|eligible) && !pause && (!m_valid || m_ready);
    assign dout_tag = dout[DATA_WIDTH+TAG_WIDTH-1 -: TAG_WIDTH];

    // Cyclic search from cur+1; descending loop so the nearest eligible index wins.
    always_comb begin
        logic [TAG_WIDTH-1:0] idx;
        idx   = '0;
        grant = cur;
        for (int unsigned k = FLUX; k >= 1; k--) begin
            idx = TAG_WIDTH'((32'(cur) + 32'(k)) % 32'(FLUX));
            if (eligible[idx]) begin
                grant = idx;
            end
        end
        if (keep) begin
            grant = cur;
        end
    end

    always_comb begin
        read = '0;
        if (can_pop) begin
            read[grant] = 1'b1;
        end
    end

    // Next-state: the output register is valid in every state but IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (can_pop) state_next = SERVE;
            end
            SERVE: begin
                if (!m_ready)     state_next = STALL;
                else if (can_pop) state_next = SERVE;
                else              state_next = IDLE;
            end
            STALL: begin
                if (m_ready) state_next = can_pop ? SERVE : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_tag     <= '0;
            tag_err   <= 1'b0;
            cur       <= TAG_WIDTH'(FLUX - 1);
            burst_cnt <= '0;
        end else begin
            state   <= state_next;
            m_valid <= (state_next != IDLE);
            if (can_pop) begin
                cur       <= grant;
                burst_cnt <= ((grant == cur) && (burst_cnt < CNT_WIDTH'(BURST)))
                             ? burst_cnt + CNT_WIDTH'(1) : CNT_WIDTH'(1);
                m_data    <= dout[DATA_WIDTH-1:0];
                m_tag     <= grant;
                if (dout_tag != grant) begin
                    tag_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_ms_rr_sched.sv
// Directed bench for fifo_ms_rr_sched with a two-stream FIFO head model.
module tb_fifo_ms_rr_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] empty;
    logic [8:0] dout;
    logic [1:0] read;
    logic [1:0] en_mask;
    logic       pause;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic [0:0] m_tag;
    logic       tag_err;
    logic       force_tag;

    logic [7:0] h0 = 8'hA0;
    logic [7:0] h1 = 8'hB0;

    int checks   = 0;
    int failures = 0;

    logic [1:0] exp_rd   [6] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01};
    logic [7:0] exp_data [6] = '{8'hA1, 8'hA2, 8'hB2, 8'hB3, 8'hA3, 8'hA4};
    logic [0:0] exp_tag  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    fifo_ms_rr_sched #(.DATA_WIDTH(8), .FLUX(2), .BURST(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .empty   (empty),
        .dout    (dout),
        .read    (read),
        .en_mask (en_mask),
        .pause   (pause),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_tag   (m_tag),
        .tag_err (tag_err)
    );

    always #5 clk = ~clk;

    // FIFO head model: word selected by read, heads advance on each pop.
    always_comb begin
        dout = read[1] ? {1'b1, h1} : {1'b0, h0};
        if (force_tag) dout[8] = 1'b1;
    end

    always @(posedge clk) begin
        if (read[0]) h0 <= h0 + 8'd1;
        if (read[1]) h1 <= h1 + 8'd1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; empty = 2'b11; en_mask = 2'b11; pause = 1'b0;
        m_ready = 1'b1; force_tag = 1'b0;
        tick; tick; #1;
        chk("rst_read", 32'(read), 32'(2'b00));
        chk("rst_valid", 32'(m_valid), 32'(1'b0));
        chk("rst_data", 32'(m_data), 32'(8'h00));
        chk("rst_tag", 32'(m_tag), 32'(1'b0));
        chk("rst_tag_err", 32'(tag_err), 32'(1'b0));

        // first pop after reset, only stream 0 available
        rst = 1'b1; empty = 2'b10; #1;
        chk("first_read", 32'(read), 32'(2'b01));
        tick;
        chk("first_valid", 32'(m_valid), 32'(1'b1));
        chk("first_tag", 32'(m_tag), 32'(1'b0));
        chk("first_data", 32'(m_data), 32'(8'hA0));

        // stream 0 masked off
        en_mask = 2'b10; empty = 2'b00; #1;
        chk("mask_read0", 32'(read), 32'(2'b10));
        tick;
        chk("mask_tag0", 32'(m_tag), 32'(1'b1));
        chk("mask_data0", 32'(m_data), 32'(8'hB0));
        #1;
        chk("mask_read1", 32'(read), 32'(2'b10));
        tick;
        chk("mask_data1", 32'(m_data), 32'(8'hB1));
        pause = 1'b1; #1;
        chk("pause_read", 32'(read), 32'(2'b00));
        chk("pause_valid", 32'(m_valid), 32'(1'b1));
        tick;
        chk("pause_drained", 32'(m_valid), 32'(1'b0));
        chk("pause_read2", 32'(read), 32'(2'b00));

        // burst rotation 0,0,1,1,0,0 at full throughput
        pause = 1'b0; en_mask = 2'b11;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("rr_read", 32'(read), 32'(exp_rd[i]));
            tick;
            chk("rr_valid", 32'(m_valid), 32'(1'b1));
            chk("rr_data", 32'(m_data), 32'(exp_data[i]));
            chk("rr_tag", 32'(m_tag), 32'(exp_tag[i]));
        end

        // backpressure for three cycles, then pop with no bubble
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_read", 32'(read), 32'(2'b00));
            chk("stall_data", 32'(m_data), 32'(8'hA4));
            chk("stall_valid", 32'(m_valid), 32'(1'b1));
            tick;
        end
        m_ready = 1'b1; #1;
        chk("resume_read", 32'(read), 32'(2'b10));
        tick;
        chk("resume_data", 32'(m_data), 32'(8'hB4));
        chk("resume_tag", 32'(m_tag), 32'(1'b1));

        // corrupted tag on a stream-0 pop
        en_mask = 2'b01; force_tag = 1'b1; #1;
        chk("terr_read", 32'(read), 32'(2'b01));
        chk("terr_before", 32'(tag_err), 32'(1'b0));
        tick;
        chk("terr_set", 32'(tag_err), 32'(1'b1));
        chk("terr_mtag", 32'(m_tag), 32'(1'b0));
        chk("terr_data", 32'(m_data), 32'(8'hA5));
        force_tag = 1'b0; en_mask = 2'b11; m_ready = 1'b0; #1;
        chk("terr_stall_read", 32'(read), 32'(2'b00));
        tick;
        chk("terr_sticky", 32'(tag_err), 32'(1'b1));
        chk("stall_hold_valid", 32'(m_valid), 32'(1'b1));
        chk("stall_hold_data", 32'(m_data), 32'(8'hA5));

        // reset while stalled mid-burst
        m_ready = 1'b1; rst = 1'b0; #1;
        chk("rst_stall_read", 32'(read), 32'(2'b00));
        tick;
        chk("rst_stall_valid", 32'(m_valid), 32'(1'b0));
        chk("rst_stall_terr", 32'(tag_err), 32'(1'b0));
        chk("rst_stall_data", 32'(m_data), 32'(8'h00));
        #1;
        chk("rst_stall_read2", 32'(read), 32'(2'b00));
        rst = 1'b1; empty = 2'b10; #1;
        chk("restart_read", 32'(read), 32'(2'b01));
        tick;
        chk("restart_tag", 32'(m_tag), 32'(1'b0));
        chk("restart_data", 32'(m_data), 32'(8'hA6));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_ms_rr_sched.md
FIFO_MS_RR_SCHED -- requirements
Module: fifo_ms_rr_sched

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the payload width per stream.
REQ-002 The block SHALL have parameter FLUX, default 2, giving the number of streams in the drained multi-stream FIFO.
REQ-003 The block SHALL have parameter BURST, default 2, giving the maximum number of consecutive grants to one stream while another stream is eligible.
REQ-004 The block SHALL derive TAG_WIDTH = $clog2(FLUX) internally, and it SHALL NOT be overridable.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low (0 = reset).
REQ-007 The block SHALL have port empty, input, FLUX bits: per-stream empty flags from the FIFO.
REQ-008 The block SHALL have port dout, input, DATA_WIDTH+TAG_WIDTH bits: FIFO head word {tag, data}, combinationally selected by read.
REQ-009 The block SHALL have port read, output, FLUX bits: one-hot pop request to the FIFO.
REQ-010 The block SHALL have port en_mask, input, FLUX bits: per-stream enable; 0 excludes the stream from arbitration.
REQ-011 The block SHALL have port pause, input, 1 bit: when 1, no new pops are issued.
REQ-012 The block SHALL have port m_valid, output, 1 bit: output word valid.
REQ-013 The block SHALL have port m_ready, input, 1 bit: consumer accepts the word when m_valid & m_ready.
REQ-014 The block SHALL have port m_data, output, DATA_WIDTH bits: registered payload.
REQ-015 The block SHALL have port m_tag, output, TAG_WIDTH bits: registered index of the stream the word came from.
REQ-016 The block SHALL have port tag_err, output, 1 bit: sticky flag set when the captured dout tag differs from the granted index.

Function
REQ-017 eligible[i] SHALL equal !empty[i] & en_mask[i].
REQ-018 can_pop SHALL equal |eligible & !pause & (!m_valid | m_ready).
REQ-019 read SHALL be combinational: one-hot of grant g when can_pop, else all zero; it SHALL never have more than one bit set.
REQ-020 Grant SHALL be cur if eligible[cur] and burst_cnt < BURST; otherwise the first eligible index searching cyclically from cur+1 (wrapping FLUX-1 to 0), which MAY return cur itself if it is the only eligible stream.
REQ-021 On each pop, cur SHALL become g; burst_cnt SHALL become burst_cnt+1 if g == cur and burst_cnt < BURST, else 1.
REQ-022 On each pop, m_data SHALL load dout[DATA_WIDTH-1:0], m_tag SHALL load g, and m_valid SHALL be 1 on the next cycle, giving 1-cycle latency from eligible to m_valid.
REQ-023 If m_valid & m_ready and no pop occurs, m_valid SHALL clear next cycle; simultaneous accept and pop SHALL keep m_valid at 1 with the new word (full throughput, one word per cycle).
REQ-024 While m_valid & !m_ready, m_data, m_tag and m_valid SHALL hold stable and read SHALL be 0.
REQ-025 The FSM SHALL have states IDLE (m_valid=0), SERVE (m_valid=1, m_ready=1 or pop pending), and STALL (m_valid=1, m_ready=0).
REQ-026 From IDLE, a pop SHALL go to SERVE.
REQ-027 From SERVE, m_ready=0 SHALL go to STALL; accept with no pop SHALL go to IDLE; accept with a pop SHALL stay in SERVE.
REQ-028 From STALL, m_ready=1 SHALL go to SERVE if a pop occurs, else to IDLE.
REQ-029 pause or en_mask changes SHALL take effect on read in the same cycle and SHALL NOT affect an already captured word.
REQ-030 tag_err SHALL set when, on a pop, dout[DATA_WIDTH+TAG_WIDTH-1 -: TAG_WIDTH] != g, and SHALL clear only on reset.
REQ-031 burst_cnt SHALL be $clog2(BURST+1) bits wide and SHALL saturate at BURST.

Reset
REQ-032 While rst == 0 at a rising edge, the block SHALL set m_valid=0, m_data=0, m_tag=0, tag_err=0, cur=FLUX-1, burst_cnt=0 and state=IDLE.
REQ-033 While rst == 0, read SHALL be forced to 0 combinationally, including mid-burst and in STALL; a held word SHALL be discarded.

Verification
REQ-034 The bench SHALL cover: after reset, empty=2'b10 and m_ready=1 -> read=2'b01 in the same cycle, then m_valid=1 with m_tag=0 and m_data equal to the stream-0 head.
REQ-035 The bench SHALL cover: both streams non-empty, BURST=2, m_ready=1 -> the grant sequence is 0,0,1,1,0,0 with one word per cycle.
REQ-036 The bench SHALL cover: m_ready=0 for 3 cycles with a word held -> read=0 and m_data stable; on m_ready=1, a pop occurs the same cycle with no bubble.
REQ-037 The bench SHALL cover: en_mask=2'b10 with both streams non-empty -> only read=2'b10 is issued; pause=1 -> read=0 while the held word still drains.
REQ-038 The bench SHALL cover: dout tag forced to 1 while read=2'b01 -> tag_err=1 and remains 1 until rst=0.
REQ-039 The bench SHALL cover: rst=0 asserted in STALL mid-burst -> the next cycle has m_valid=0 and read=0, and after release the grant restarts at stream 0.
